rvfi_dmem_model: RTL
====================

# rvfi_dmem_model

Parametrised data-memory model for the formal/simulation harness around `otter_mcu`. It replaces free-running random `dmem_r_data` with a consistent shadow memory: bytes the core has written read back as written, and untouched bytes come from solver-controlled random data. It adds configurable read latency, a busy handshake, an optional bounded random stall and a sticky protocol-error flag. It is instantiated in the RVFI wrapper between the core's dmem port and the formal environment.

## Interface
- `DEPTH`, 4: number of shadow entries (1..16).
- `LATENCY`, 1: cycles from read accept to `dmem_r_valid` (0..4).
- `MAX_STALL`, 3: maximum consecutive stall cycles per request. Used only with `RVFI_DMEM_STALL_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rand_data`  in  32  free solver input; fill for unshadowed bytes.
- `rand_stall`  in  1  free solver input; stall request.
- `dmem_r_en`  in  1  read request.
- `dmem_w_en`  in  1  write request.
- `dmem_w_strb`  in  4  byte enables; bit i covers byte i.
- `dmem_addr`  in  32  byte address; tag is `dmem_addr[31:2]`.
- `dmem_w_data`  in  32  write data.
- `dmem_r_data`  out  32  read data; holds its last returned value.
- `dmem_r_valid`  out  1  one-cycle pulse marking `dmem_r_data` valid.
- `dmem_busy`  out  1  request not accepted this cycle.
- `proto_err`  out  1  sticky protocol violation.

## Operation
- Accept: a request is accepted at a rising edge when (`dmem_r_en` | `dmem_w_en`) is high and `dmem_busy` is low.
- Each entry holds: valid bit, 30-bit tag, 32-bit data, and a 4-bit byte-valid mask.
- Write accept:
  - Tag hit: merge the strobed bytes and OR `dmem_w_strb` into the mask.
  - Miss: allocate the lowest-index invalid entry. If all entries are valid, evict the entry at the round-robin victim pointer, then increment the pointer (wraps at DEPTH).
  - New entry: data = strobed bytes, mask = strobe.
  - `dmem_w_strb`=0 leaves the table unchanged.
- Read accept:
  - Lookup uses the table state before the edge.
  - Byte i is the shadow byte if there is a hit and mask[i] is set; otherwise it is `rand_data` byte i, sampled in the accept cycle.
  - The result enters a LATENCY-deep delay line.
- Read and write in the same cycle: neither is accepted, `proto_err` is set, and `dmem_busy` is unaffected.
- Any request while `dmem_busy`=1 is not accepted and is not an error; the core must hold it.
- States:
  - IDLE → WAIT on read accept when LATENCY>1.
  - WAIT counts LATENCY-1 cycles, then → IDLE.
  - `dmem_busy`=1 throughout WAIT.
- Reset mid-operation:
  - All entries are invalidated, the victim pointer returns to 0, and the state returns to IDLE.
  - Any in-flight read is dropped with no `dmem_r_valid`.

## Timing
- Reset values: `dmem_r_data`=0, `dmem_r_valid`=0, `dmem_busy`=0, `proto_err`=0.
- LATENCY=0: `dmem_r_data` is combinational from the lookup and `dmem_r_valid`=`dmem_r_en` in the accept cycle. Reads never raise busy.
- LATENCY=1: `dmem_r_valid` is high in the cycle after accept. Back-to-back reads are accepted every cycle.
- LATENCY=N>1: `dmem_r_valid` is high exactly N cycles after accept, and busy is high for the N-1 cycles between.
  - A new request may be accepted in the `dmem_r_valid` cycle.
- Write-then-read of the same word in the next cycle returns the written bytes.
- `proto_err` clears only on reset.

## Configuration
- `RVFI_DMEM_STALL_EN` defined:
  - `dmem_busy` additionally asserts while a request is pending, `rand_stall`=1, and the stall counter < MAX_STALL.
  - The counter increments for each stalled pending cycle and clears on accept, on reset, or when no request is pending.
  - After MAX_STALL consecutive stalls the request is forced to accept.
- Undefined: `rand_stall` is ignored, no stall counter exists, and busy comes only from WAIT.

## Test plan
- Write 0xDEADBEEF, strb 0xF, to 0x100; read 0x100 with `rand_data`=0x0 → `dmem_r_data`=0xDEADBEEF, `dmem_r_valid` LATENCY cycles after accept.
- Write 0x000000AA, strb 0x1, to 0x200; read 0x200 with `rand_data`=0x11223344 → 0x112233AA.
- DEPTH=4: write 5 distinct words 0x0/0x4/0x8/0xC/0x10; read 0x0 with `rand_data`=0x55555555 → 0x55555555 (evicted). Read 0x10 → its written value.
- `dmem_r_en`=`dmem_w_en`=1 for one cycle → `proto_err`=1 and stays 1, table unchanged, no `dmem_r_valid`.
- LATENCY=3: read accepted in cycle 0 → busy in cycles 1–2, `dmem_r_valid` in cycle 3. Assert `rst_n`=0 in cycle 2 → no `dmem_r_valid`, all outputs 0.
- STALL_EN, MAX_STALL=3: read held with `rand_stall`=1 continuously → busy for 3 cycles, accepted on the 4th.

Source files
------------

// File: rtl/rvfi_dmem_model.sv
// Shadow data memory for the otter_mcu RVFI harness: written bytes read back, others come from rand_data.
// Optional bounded random stall enabled by defining RVFI_DMEM_STALL_EN.
module rvfi_dmem_model #(
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 1,
  parameter int MAX_STALL = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rand_data,
  input  logic        rand_stall,
  input  logic        dmem_r_en,
  input  logic        dmem_w_en,
  input  logic [3:0]  dmem_w_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_w_data,
  output logic [31:0] dmem_r_data,
  output logic        dmem_r_valid,
  output logic        dmem_busy,
  output logic        proto_err
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PL    = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [2:0] WAIT_LAST = 3'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_wait_cnt;
  logic [DEPTH-1:0]  r_ent_vld;
  logic [29:0]       r_tag [DEPTH];
  logic [31:0]       r_dat [DEPTH];
  logic [3:0]        r_msk [DEPTH];
  logic [IDX_W-1:0]  r_victim;

  logic              w_req, w_conflict, w_acc_rd, w_acc_wr, w_accept;
  logic              w_wait_busy, w_stall;
  logic              w_hit, w_free;
  logic [IDX_W-1:0]  w_hit_idx, w_free_idx, w_alloc_idx;
  logic [31:0]       w_rd_data, w_merge_data, w_new_data;
  logic              w_unused;

  assign w_unused   = ^{dmem_addr[1:0], rand_stall, (MAX_STALL > 0)};
  assign w_req      = dmem_r_en | dmem_w_en;
  assign w_conflict = dmem_r_en & dmem_w_en;
  assign dmem_busy  = w_wait_busy | w_stall;
  assign w_acc_rd   = dmem_r_en & ~dmem_w_en & ~dmem_busy;
  assign w_acc_wr   = dmem_w_en & ~dmem_r_en & ~dmem_busy;
  assign w_accept   = w_acc_rd | w_acc_wr;

  // Lowest-index hit and lowest-index free entry
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_ent_vld[i] && (r_tag[i] == dmem_addr[31:2])) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_ent_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_alloc_idx = w_free ? w_free_idx : r_victim;

  always_comb begin
    w_rd_data    = rand_data;
    w_merge_data = r_dat[w_hit_idx];
    w_new_data   = '0;
    for (int b = 0; b < 4; b++) begin
      if (w_hit && r_msk[w_hit_idx][b]) w_rd_data[8*b +: 8] = r_dat[w_hit_idx][8*b +: 8];
      if (dmem_w_strb[b]) begin
        w_merge_data[8*b +: 8] = dmem_w_data[8*b +: 8];
        w_new_data[8*b +: 8]   = dmem_w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent_vld <= '0;
      r_victim  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (w_conflict) proto_err <= 1'b1;
      if (w_acc_wr && (dmem_w_strb != 4'b0) && !w_hit) begin
        r_ent_vld[w_alloc_idx] <= 1'b1;
        if (!w_free) r_victim <= (r_victim == IDX_W'(DEPTH - 1)) ? '0 : r_victim + 1'b1;
      end
    end
  end

  // Entry payload needs no reset: it is qualified by r_ent_vld
  always_ff @(posedge clk) begin
    if (w_acc_wr && (dmem_w_strb != 4'b0)) begin
      if (w_hit) begin
        r_dat[w_hit_idx] <= w_merge_data;
        r_msk[w_hit_idx] <= r_msk[w_hit_idx] | dmem_w_strb;
      end else begin
        r_tag[w_alloc_idx] <= dmem_addr[31:2];
        r_dat[w_alloc_idx] <= w_new_data;
        r_msk[w_alloc_idx] <= dmem_w_strb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc_rd && (LATENCY > 1)) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_wait_cnt == WAIT_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wait_busy = (r_state == S_WAIT);
  end

`ifdef RVFI_DMEM_STALL_EN
  localparam int SC_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  logic [SC_W-1:0] r_stall_cnt;

  assign w_stall = w_req & rand_stall & (r_stall_cnt < SC_W'(MAX_STALL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_stall_cnt <= '0;
    else if (!w_req || w_accept) r_stall_cnt <= '0;
    else if (w_stall)            r_stall_cnt <= r_stall_cnt + 1'b1;
  end
`else
  assign w_stall = 1'b0;
`endif

  generate
    if (LATENCY == 0) begin : g_lat0
      logic [31:0] r_hold;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_hold <= '0;
        else if (w_acc_rd) r_hold <= w_rd_data;
      end
      assign dmem_r_data  = w_acc_rd ? w_rd_data : r_hold;
      assign dmem_r_valid = w_acc_rd;
    end else begin : g_latn
      logic [PL-1:0] r_vld_p;
      logic [31:0]   r_dat_p [PL];
      // Each stage only loads when a valid result moves in, so the last stage holds
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_p <= '0;
          for (int s = 0; s < PL; s++) r_dat_p[s] <= '0;
        end else begin
          r_vld_p[0] <= w_acc_rd;
          if (w_acc_rd) r_dat_p[0] <= w_rd_data;
          for (int s = 1; s < PL; s++) begin
            r_vld_p[s] <= r_vld_p[s-1];
            if (r_vld_p[s-1]) r_dat_p[s] <= r_dat_p[s-1];
          end
        end
      end
      assign dmem_r_data  = r_dat_p[PL-1];
      assign dmem_r_valid = r_vld_p[PL-1];
    end
  endgenerate

endmodule
